channel_select_pipe: RTL and testbench

Parametrised, registered N-channel data selector with valid/ready handshaking on every input and on the output. It generalises the team's fixed 8:1 combinational mux with a configurable channel count and two selection modes (fixed select and round-robin arbitration), plus a one-entry output register. It sits between multiple data producers (address/data sources) and a single consumer stage in the datapath.

---
 rtl/channel_select_pipe_pkg.sv | 15 +
 rtl/channel_select_pipe_if.sv | 29 ++
 rtl/channel_select_pipe_rr_arbiter.sv | 37 +++
 rtl/channel_select_pipe.sv | 125 ++++++++++++
 tb/tb_channel_select_pipe.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/channel_select_pipe_pkg.sv
// Shared encodings for the channel select pipe: selection modes and
// output register occupancy.
package channel_select_pipe_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/channel_select_pipe_if.sv
// Handshake bundle between N producers, the selector and one consumer.
// master = producer/consumer side, slave = the selector itself.
interface channel_select_pipe_if #(
  parameter int SIZE      = 16,
  parameter int CHANNELS  = 8,
  parameter int SEL_WIDTH = 3
);

  logic                     mode;
  logic [SEL_WIDTH-1:0]     sel;
  logic [CHANNELS*SIZE-1:0] in_data;
  logic [CHANNELS-1:0]      in_valid;
  logic [CHANNELS-1:0]      in_ready;
  logic [SIZE-1:0]          out;
  logic                     out_valid;
  logic                     out_ready;
  logic [SEL_WIDTH-1:0]     out_chan;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out, out_valid, out_chan
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out, out_valid, out_chan
  );

endinterface

// File: rtl/channel_select_pipe_rr_arbiter.sv
// Round-robin arbiter: the first requester found when scanning cyclically
// from ptr+1 around to ptr (inclusive) wins. Purely combinational; the
// caller owns and updates the pointer.
module channel_select_pipe_rr_arbiter #(
  parameter int CHANNELS = 8,
  parameter int IDX_W    = 3
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx
);

  logic found_s;
  int   cand_s;

  // Cyclic priority search starting just after the last winner
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    cand_s    = 0;
    for (int i = 1; i <= CHANNELS; i++) begin
      cand_s = (int'(ptr) + i) % CHANNELS;
      for (int k = 0; k < CHANNELS; k++) begin
        if (!found_s && (cand_s == k) && req[k]) begin
          grant[k]  = 1'b1;
          grant_idx = IDX_W'(k);
          found_s   = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

endmodule

// File: rtl/channel_select_pipe.sv
// N-channel registered data selector with valid/ready on every input and
// on the output. Fixed-select or round-robin grant feeds a one-entry
// output register that can drain and refill in the same cycle.
module channel_select_pipe
  import channel_select_pipe_pkg::*;
#(
  parameter int SIZE      = 16,
  parameter int CHANNELS  = 8,
  parameter int SEL_WIDTH = 3
) (
  input logic                  clk,
  input logic                  rst,
  channel_select_pipe_if.slave bus
);

  state_e                state_r;
  state_e                state_n_s;
  logic [SIZE-1:0]       out_r;
  logic [SEL_WIDTH-1:0]  out_chan_r;
  logic [SEL_WIDTH-1:0]  rr_ptr_r;

  logic [CHANNELS-1:0]   fix_grant_s;
  logic [CHANNELS-1:0]   rr_grant_s;
  logic [SEL_WIDTH-1:0]  rr_idx_s;
  logic [CHANNELS-1:0]   grant_s;
  logic [SEL_WIDTH-1:0]  grant_idx_s;
  logic [CHANNELS-1:0]   in_ready_s;
  logic                  can_load_s;
  logic                  load_s;
  logic [SIZE-1:0]       load_data_s;

  channel_select_pipe_rr_arbiter #(
    .CHANNELS (CHANNELS),
    .IDX_W    (SEL_WIDTH)
  ) u_rr_arbiter (
    .req       (bus.in_valid),
    .ptr       (rr_ptr_r),
    .grant     (rr_grant_s),
    .grant_idx (rr_idx_s)
  );

  // Fixed-select grant (out-of-range SEL matches no channel) and mode mux
  always_comb begin
    fix_grant_s = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      fix_grant_s[k] = bus.in_valid[k] && (bus.sel == SEL_WIDTH'(k));
    end
    if (bus.mode == MODE_RR) begin
      grant_s     = rr_grant_s;
      grant_idx_s = rr_idx_s;
    end else begin
      grant_s     = fix_grant_s;
      grant_idx_s = bus.sel;
    end
  end

  // Input handshake: only the granted channel sees ready, and only when
  // the output register can take a word this cycle
  always_comb begin
    can_load_s  = (state_r == ST_EMPTY) || bus.out_ready;
    load_data_s = '0;
    if (rst) begin
      in_ready_s = '0;
    end else begin
      in_ready_s = grant_s & {CHANNELS{can_load_s}};
    end
    load_s = |(in_ready_s & bus.in_valid);
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant_s[k]) begin
        load_data_s = bus.in_data[k*SIZE +: SIZE];
      end else begin
        load_data_s = load_data_s;
      end
    end
  end

  // Output register occupancy: a load always wins over a drain
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (load_s) begin
          state_n_s = ST_FULL;
        end else begin
          state_n_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (load_s) begin
          state_n_s = ST_FULL;
        end else if (bus.out_ready) begin
          state_n_s = ST_EMPTY;
        end else begin
          state_n_s = ST_FULL;
        end
      end
      default: state_n_s = ST_EMPTY;
    endcase
  end

  // State, output word/channel and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_EMPTY;
      out_r      <= '0;
      out_chan_r <= '0;
      rr_ptr_r   <= SEL_WIDTH'(CHANNELS - 1);
    end else begin
      state_r <= state_n_s;
      if (load_s) begin
        out_r      <= load_data_s;
        out_chan_r <= grant_idx_s;
      end
      if (load_s && (bus.mode == MODE_RR)) begin
        rr_ptr_r <= grant_idx_s;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out       = out_r;
  assign bus.out_valid = (state_r == ST_FULL);
  assign bus.out_chan  = out_chan_r;

endmodule

// File: tb/tb_channel_select_pipe.sv
// Directed bench for channel_select_pipe: an 8-channel instance for the
// main scenarios and a 6-channel instance for out-of-range SEL.
module tb_channel_select_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  channel_select_pipe_if #(.SIZE(16), .CHANNELS(8), .SEL_WIDTH(3)) b8 ();
  channel_select_pipe_if #(.SIZE(16), .CHANNELS(6), .SEL_WIDTH(3)) b6 ();

  channel_select_pipe #(.SIZE(16), .CHANNELS(8), .SEL_WIDTH(3)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8)
  );

  channel_select_pipe #(.SIZE(16), .CHANNELS(6), .SEL_WIDTH(3)) u_dut6 (
    .clk (clk),
    .rst (rst),
    .bus (b6)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set8(input int k, input logic [15:0] v);
    b8.in_data[k*16 +: 16] = v;
  endtask

  logic [31:0] exp_chan;

  initial begin
    b8.mode = 1'b0; b8.sel = 3'd0; b8.in_data = '0; b8.in_valid = 8'hFF; b8.out_ready = 1'b0;
    b6.mode = 1'b0; b6.sel = 3'd0; b6.in_data = '0; b6.in_valid = 6'h3F; b6.out_ready = 1'b0;

    // reset: no ready even with all channels valid
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_in_ready8", 32'(b8.in_ready), 32'h0);
    check_eq("rst_in_ready6", 32'(b6.in_ready), 32'h0);
    check_eq("rst_out", 32'(b8.out), 32'h0);
    check_eq("rst_out_valid", 32'(b8.out_valid), 32'h0);
    check_eq("rst_out_chan", 32'(b8.out_chan), 32'h0);
    rst = 1'b0;
    b8.in_valid = 8'h00;
    b6.in_valid = 6'h00;

    // fixed select of channel 2
    @(negedge clk);
    b8.mode = 1'b0; b8.sel = 3'd2; set8(2, 16'hA5A5);
    b8.in_valid = 8'b0000_0100; b8.out_ready = 1'b1;
    #1 check_eq("fix_in_ready", 32'(b8.in_ready), 32'h04);
    @(negedge clk);
    check_eq("fix_out", 32'(b8.out), 32'hA5A5);
    check_eq("fix_out_valid", 32'(b8.out_valid), 32'h1);
    check_eq("fix_out_chan", 32'(b8.out_chan), 32'h2);
    b8.in_valid = 8'h00;
    @(negedge clk);
    check_eq("drain_valid", 32'(b8.out_valid), 32'h0);
    check_eq("drain_hold_out", 32'(b8.out), 32'hA5A5);

    // round robin, all channels valid: 0..7,0 one per cycle
    for (int k = 0; k < 8; k++) set8(k, 16'h1000 + 16'(k));
    b8.mode = 1'b1; b8.in_valid = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      #1 check_eq("rr_all_ready", 32'(b8.in_ready), 32'h1 << (i % 8));
      @(negedge clk);
      check_eq("rr_all_chan", 32'(b8.out_chan), 32'(i % 8));
      check_eq("rr_all_out", 32'(b8.out), 32'h1000 + 32'(i % 8));
      check_eq("rr_all_valid", 32'(b8.out_valid), 32'h1);
    end
    b8.in_valid = 8'h00;
    @(negedge clk);
    check_eq("rr_all_drain", 32'(b8.out_valid), 32'h0);

    // round robin, channels 1 and 5 alternate
    set8(1, 16'h1111); set8(5, 16'h5555);
    b8.in_valid = 8'b0010_0010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_chan = (i % 2 == 0) ? 32'd1 : 32'd5;
      check_eq("rr_pair_chan", 32'(b8.out_chan), exp_chan);
      check_eq("rr_pair_out", 32'(b8.out), (i % 2 == 0) ? 32'h1111 : 32'h5555);
    end
    b8.in_valid = 8'h00;
    @(negedge clk);
    check_eq("rr_pair_drain", 32'(b8.out_valid), 32'h0);

    // backpressure: hold 4 cycles, then drain and refill in one cycle
    b8.mode = 1'b0; b8.sel = 3'd3; set8(3, 16'h3333);
    b8.in_valid = 8'b0000_1000; b8.out_ready = 1'b1;
    #1 check_eq("bp_first_ready", 32'(b8.in_ready), 32'h08);
    @(negedge clk);
    check_eq("bp_first_out", 32'(b8.out), 32'h3333);
    b8.out_ready = 1'b0; set8(3, 16'h4444);
    for (int i = 0; i < 4; i++) begin
      #1 check_eq("bp_in_ready", 32'(b8.in_ready), 32'h0);
      @(negedge clk);
      check_eq("bp_out", 32'(b8.out), 32'h3333);
      check_eq("bp_chan", 32'(b8.out_chan), 32'h3);
      check_eq("bp_valid", 32'(b8.out_valid), 32'h1);
    end
    b8.out_ready = 1'b1;
    #1 check_eq("bp_refill_ready", 32'(b8.in_ready), 32'h08);
    @(negedge clk);
    check_eq("bp_refill_out", 32'(b8.out), 32'h4444);
    check_eq("bp_refill_valid", 32'(b8.out_valid), 32'h1);

    // reset while FULL under backpressure; RR restarts at channel 0
    b8.in_valid = 8'h00; b8.out_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_valid", 32'(b8.out_valid), 32'h0);
    check_eq("mid_rst_out", 32'(b8.out), 32'h0);
    rst = 1'b0;
    b8.mode = 1'b1; b8.in_valid = 8'hFF; b8.out_ready = 1'b1;
    #1 check_eq("post_rst_ready", 32'(b8.in_ready), 32'h01);
    @(negedge clk);
    check_eq("post_rst_chan", 32'(b8.out_chan), 32'h0);
    check_eq("post_rst_out", 32'(b8.out), 32'h1000);
    b8.in_valid = 8'h00;

    // 6 channels: SEL 7 and 6 never grant, SEL 5 does
    b6.in_data[5*16 +: 16] = 16'hBEEF;
    b6.mode = 1'b0; b6.in_valid = 6'h3F; b6.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b6.sel = (i % 2 == 0) ? 3'd7 : 3'd6;
      #1 check_eq("oor_in_ready", 32'(b6.in_ready), 32'h0);
      @(negedge clk);
      check_eq("oor_valid", 32'(b6.out_valid), 32'h0);
    end
    b6.sel = 3'd5;
    #1 check_eq("ch6_sel5_ready", 32'(b6.in_ready), 32'h20);
    @(negedge clk);
    check_eq("ch6_sel5_chan", 32'(b6.out_chan), 32'h5);
    check_eq("ch6_sel5_out", 32'(b6.out), 32'hBEEF);
    b6.in_valid = 6'h00;

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
